// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer : four-state controller that decodes one MIPS instruction,
//                 runs it on the ALU and writes the result to its register file.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module alu_sequencer #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  input  logic [4:0]          dbg_addr,
  output logic [31:0]         dbg_data,
  output logic                done,
  output logic [31:0]         result,
  output logic [4:0]          instr_id,
  output logic                exc_illegal,
  output logic                exc_ovf,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_DECODE    = 2'd1;
  localparam logic [1:0] S_EXECUTE   = 2'd2;
  localparam logic [1:0] S_WRITEBACK = 2'd3;

  logic [1:0]          r_state;
  logic [31:0]         r_ir;
  logic [31:0]         r_regs [32];
  logic [4:0]          r_id;
  logic [4:0]          r_dst;
  logic [31:0]         r_opa;
  logic [31:0]         r_opb;
  logic [31:0]         r_res;
  logic                r_ovf;
  logic                r_done;
  logic [31:0]         r_result;
  logic [4:0]          r_instr_id;
  logic                r_exc_ill;
  logic                r_exc_ovf;
  logic [RETIRE_W-1:0] r_retired;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_simm;
  logic [31:0] w_zimm;
  logic [4:0]  w_id;
  logic [4:0]  w_dst;
  logic [31:0] w_opa;
  logic [31:0] w_opb;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_res;
  logic        w_ovf;

  assign w_op     = r_ir[31:26];
  assign w_fn     = r_ir[5:0];
  assign w_rs_val = r_regs[r_ir[25:21]];
  assign w_rt_val = r_regs[r_ir[20:16]];
  assign w_simm   = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_zimm   = {16'h0000, r_ir[15:0]};

  always_comb begin
    w_id  = 5'd0;
    w_dst = r_ir[15:11];
    w_opa = w_rs_val;
    w_opb = w_rt_val;
    if (w_op == 6'h00) begin
      case (w_fn)
        6'h20: w_id = 5'd1;
        6'h22: w_id = 5'd2;
        6'h21: w_id = 5'd3;
        6'h23: w_id = 5'd4;
        6'h24: w_id = 5'd7;
        6'h25: w_id = 5'd8;
        6'h00, 6'h02: begin
          // Shifts operate on rt; the shift amount rides in operand B.
          w_id  = (w_fn == 6'h00) ? 5'd11 : 5'd12;
          w_opa = w_rt_val;
          w_opb = {27'd0, r_ir[10:6]};
        end
        default: w_id = 5'd0;
      endcase
    end else begin
      w_dst = r_ir[20:16];
      case (w_op)
        6'h08: begin w_id = 5'd5;  w_opb = w_simm; end
        6'h09: begin w_id = 5'd6;  w_opb = w_simm; end
        6'h0C: begin w_id = 5'd9;  w_opb = w_zimm; end
        6'h0D: begin w_id = 5'd10; w_opb = w_zimm; end
        default: w_id = 5'd0;
      endcase
    end
  end

  assign w_sum  = r_opa + r_opb;
  assign w_diff = r_opa - r_opb;

  always_comb begin
    w_res = 32'd0;
    w_ovf = 1'b0;
    case (r_id)
      5'd1, 5'd5: begin
        w_res = w_sum;
        w_ovf = (r_opa[31] == r_opb[31]) && (w_sum[31] != r_opa[31]);
      end
      5'd3, 5'd6: w_res = w_sum;
      5'd2: begin
        w_res = w_diff;
        w_ovf = (r_opa[31] != r_opb[31]) && (w_diff[31] != r_opa[31]);
      end
      5'd4:        w_res = w_diff;
      5'd7, 5'd9:  w_res = r_opa & r_opb;
      5'd8, 5'd10: w_res = r_opa | r_opb;
      5'd11:       w_res = r_opa << r_opb[4:0];
      5'd12:       w_res = r_opa >> r_opb[4:0];
      default:     w_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ir       <= '0;
      r_id       <= '0;
      r_dst      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_res      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_instr_id <= '0;
      r_exc_ill  <= 1'b0;
      r_exc_ovf  <= 1'b0;
      r_retired  <= '0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_done    <= 1'b0;
      r_exc_ill <= 1'b0;
      r_exc_ovf <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_id    <= w_id;
          r_dst   <= w_dst;
          r_opa   <= w_opa;
          r_opb   <= w_opb;
          r_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          r_res   <= w_res;
          r_ovf   <= w_ovf;
          r_state <= S_WRITEBACK;
        end
        default: begin
          r_done     <= 1'b1;
          r_instr_id <= r_id;
          r_result   <= (r_id == 5'd0) ? 32'd0 : r_res;
          r_exc_ill  <= (r_id == 5'd0);
          r_exc_ovf  <= r_ovf;
          // Register 0 is never written, so it reads as zero without a mux.
          if ((r_id != 5'd0) && !r_ovf) begin
            if (r_dst != 5'd0) r_regs[r_dst] <= r_res;
            r_retired <= r_retired + RETIRE_W'(1);
          end
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : r_regs[dbg_addr];
  assign done        = r_done;
  assign result      = r_result;
  assign instr_id    = r_instr_id;
  assign exc_illegal = r_exc_ill;
  assign exc_ovf     = r_exc_ovf;
  assign retired     = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// tb_alu_sequencer : directed and random instruction streams checked against
//                    an architectural model of the register file.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  localparam int RW = 4;

  logic          clk;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [4:0]    dbg_addr;
  logic [31:0]   dbg_data;
  logic          done;
  logic [31:0]   result;
  logic [4:0]    instr_id;
  logic          exc_illegal;
  logic          exc_ovf;
  logic [RW-1:0] retired;

  alu_sequencer #(.RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .done(done),
    .result(result), .instr_id(instr_id), .exc_illegal(exc_illegal),
    .exc_ovf(exc_ovf), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mregs [32];
  int          mret;
  logic [4:0]  m_id;
  logic [31:0] m_res;
  logic        m_ill, m_ovf, m_wen;
  logic [4:0]  m_dst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt,
                                        input int imm);
    itype = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Architectural meaning of one instruction, using wide signed arithmetic for overflow.
  function automatic void model(input logic [31:0] ir);
    logic [31:0] a, b, simm, zimm;
    longint sa, sb, s;
    longint lim = 64'sd2147483647;
    a = mregs[ir[25:21]];
    b = mregs[ir[20:16]];
    simm = {{16{ir[15]}}, ir[15:0]};
    zimm = {16'h0, ir[15:0]};
    m_id = 0; m_res = 0; m_ovf = 0; m_dst = ir[15:11];
    if (ir[31:26] == 6'h00) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      case (ir[5:0])
        6'h20: begin m_id = 1; m_res = a + b; s = sa + sb; m_ovf = (s > lim) || (s < -lim - 1); end
        6'h22: begin m_id = 2; m_res = a - b; s = sa - sb; m_ovf = (s > lim) || (s < -lim - 1); end
        6'h21: begin m_id = 3; m_res = a + b; end
        6'h23: begin m_id = 4; m_res = a - b; end
        6'h24: begin m_id = 7; m_res = a & b; end
        6'h25: begin m_id = 8; m_res = a | b; end
        6'h00: begin m_id = 11; m_res = b << ir[10:6]; end
        6'h02: begin m_id = 12; m_res = b >> ir[10:6]; end
        default: m_id = 0;
      endcase
    end else begin
      m_dst = ir[20:16];
      sa = longint'($signed(a)); sb = longint'($signed(simm));
      case (ir[31:26])
        6'h08: begin m_id = 5; m_res = a + simm; s = sa + sb; m_ovf = (s > lim) || (s < -lim - 1); end
        6'h09: begin m_id = 6; m_res = a + simm; end
        6'h0C: begin m_id = 9; m_res = a & zimm; end
        6'h0D: begin m_id = 10; m_res = a | zimm; end
        default: m_id = 0;
      endcase
    end
    m_ill = (m_id == 0);
    if (m_ill) begin m_res = 0; m_dst = 0; end
    m_wen = !m_ill && !m_ovf;
  endfunction

  function automatic void model_commit();
    if (m_wen) begin
      if (m_dst != 0) mregs[m_dst] = m_res;
      mret = (mret + 1) % (1 << RW);
    end
  endfunction

  task automatic peek(input int addr, input logic [31:0] exp, input string tag);
    dbg_addr = 5'(addr);
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic chk_all_regs(input string tag);
    for (int i = 0; i < 32; i++) peek(i, mregs[i], tag);
  endtask

  task automatic run_one(input logic [31:0] ir);
    logic [31:0] old;
    model(ir);
    old = mregs[m_dst];
    @(negedge clk);
    dbg_addr = m_dst; instr = ir; instr_valid = 1'b1;
    #1 chk("ready_idle", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = $urandom;
    chk("ready_decode", instr_ready, 0);
    chk("done_t0", done, 0);
    @(posedge clk); #1;
    chk("ready_exec", instr_ready, 0);
    chk("done_t1", done, 0);
    @(posedge clk); #1;
    chk("ready_wb", instr_ready, 0);
    chk("done_t2", done, 0);
    chk("dbg_old", dbg_data, old);
    @(posedge clk); #1;
    model_commit();
    chk("done_t3", done, 1);
    chk("ready_t3", instr_ready, 1);
    chk("result", result, m_res);
    chk("instr_id", instr_id, m_id);
    chk("exc_illegal", exc_illegal, m_ill);
    chk("exc_ovf", exc_ovf, m_ovf);
    chk("retired", retired, mret);
    chk("dbg_new", dbg_data, mregs[m_dst]);
    @(posedge clk); #1;
    chk("done_t4", done, 0);
    chk("exc_ill_clr", exc_illegal, 0);
    chk("exc_ovf_clr", exc_ovf, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    int k = $urandom_range(0, 12);
    int rs = $urandom_range(0, 7), rt = $urandom_range(0, 7), rd = $urandom_range(0, 7);
    int sh = $urandom_range(0, 31), imm = $urandom_range(0, 65535);
    case (k)
      0: return rtype(rs, rt, rd, 0, 'h20);
      1: return rtype(rs, rt, rd, 0, 'h22);
      2: return rtype(rs, rt, rd, 0, 'h21);
      3: return rtype(rs, rt, rd, 0, 'h23);
      4: return rtype(rs, rt, rd, 0, 'h24);
      5: return rtype(rs, rt, rd, 0, 'h25);
      6: return rtype(0, rt, rd, sh, 'h00);
      7: return rtype(0, rt, rd, sh, 'h02);
      8: return itype('h08, rs, rt, imm);
      9: return itype('h09, rs, rt, imm);
      10: return itype('h0C, rs, rt, imm);
      11: return itype('h0D, rs, rt, imm);
      default: return ($urandom_range(0, 1) == 0) ? itype('h3F, rs, rt, imm)
                                                  : rtype(rs, rt, rd, sh, 'h3F);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] tp [4];
    int xfers;
    reset = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mret = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_id", instr_id, 0);
    chk("rst_ill", exc_illegal, 0);
    chk("rst_ovf", exc_ovf, 0);
    chk("rst_retired", retired, 0);
    reset = 1'b0;
    chk_all_regs("rst_reg");

    run_one(32'h34010005);
    run_one(32'h34020003);
    run_one(32'h00221820);
    peek(3, 32'd8, "plan_r3");
    chk("plan_id_add", instr_id, 1);
    chk("plan_ret3", retired, 3);
    run_one(32'h00412022);
    peek(4, 32'hFFFFFFFE, "plan_r4");
    run_one(32'h00012900);
    peek(5, 32'h50, "plan_r5");
    run_one(itype('h0D, 0, 6, 1));
    run_one(rtype(0, 6, 6, 31, 'h00));
    peek(6, 32'h80000000, "plan_r6");
    run_one(rtype(6, 6, 7, 0, 'h20));
    peek(7, 32'h0, "plan_r7_ovf");
    chk("plan_ret_ovf", retired, 7);
    run_one(rtype(6, 6, 7, 0, 'h21));
    chk("plan_ret_addu", retired, 8);
    run_one(32'hFC000000);
    chk("plan_ill_res", result, 0);
    run_one(32'h3400FFFF);
    peek(0, 32'h0, "plan_r0");
    chk_all_regs("plan_regs");

    // Back-to-back stream with instr_valid held high.
    tp[0] = itype('h0D, 0, 8, 'h11);
    tp[1] = itype('h0D, 8, 9, 'h200);
    tp[2] = rtype(8, 9, 10, 0, 'h21);
    tp[3] = rtype(10, 8, 11, 0, 'h23);
    xfers = 0;
    @(negedge clk);
    instr_valid = 1'b1; instr = tp[0];
    for (int cyc = 0; cyc <= 16; cyc++) begin
      chk("tp_ready", instr_ready, (cyc % 4) == 0);
      chk("tp_done", done, ((cyc % 4) == 0) && (cyc > 0));
      if (cyc > 0 && (cyc % 4) == 0) chk("tp_retired", retired, mret);
      if (instr_ready && instr_valid) begin
        model(tp[xfers]);
        model_commit();
        xfers++;
      end
      @(negedge clk);
      if (xfers < 4) instr = tp[xfers];
      else instr_valid = 1'b0;
    end
    chk("tp_xfers", xfers, 4);
    chk_all_regs("tp_regs");

    // Random traffic; the narrow counter wraps several times here.
    for (int n = 0; n < 40; n++) run_one(rand_instr());
    chk_all_regs("rand_regs");

    // Reset dropped in the middle of an add.
    run_one(32'h34010005);
    run_one(32'h34020003);
    @(negedge clk);
    instr = 32'h00221820; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", instr_ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_retired", retired, 0);
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mret = 0;
    chk_all_regs("mid_rst_reg");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 chk("mid_rst_hold_done", done, 0);
    end
    reset = 1'b0;
    run_one(32'h3403002A);
    peek(3, 32'h2A, "post_rst_r3");
    chk("post_rst_ret", retired, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
